gpio_mailbox: RTL and testbench

- Memory-mapped mailbox between the processor's dmem port and the GPIO protocol engine.
- Processor software builds a 128-bit outbound message from four 32-bit word writes, then issues a send command. The block drives the data_ready/done handshake into the protocol engine.
- Inbound 128-bit messages from the protocol engine are latched and exposed as four readable words plus status bits.
- Sits directly upstream (TX) and downstream (RX) of the GPIO protocol engine; address decode sits alongside dmem.

---
 rtl/gpio_mailbox.sv | 161 ++++++++++++++++
 tb/tb_gpio_mailbox.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_mailbox.sv
// Memory-mapped mailbox between the processor dmem port and the GPIO protocol engine.
// Four TX words plus a send command drive data_ready/done; inbound messages are latched as four RX words.
module gpio_mailbox #(
  parameter logic [11:0] ADDR_BASE = 12'hFF0,
  parameter int          TX_WORDS  = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [11:0]  address_dmem,
  input  logic [31:0]  data,
  input  logic         wren,
  output logic         mb_sel,
  output logic [31:0]  q_mb,
  output logic         data_ready,
  input  logic         done,
  output logic [127:0] message_out,
  input  logic [127:0] message_in,
  input  logic         rx_strobe
);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_DRAIN = 2'd2
  } tx_state_t;

  tx_state_t   state_reg, state_next;
  logic [11:0] offset_full;
  logic [3:0]  offset;
  logic        wr_en;
  logic        is_tx_word;
  logic        is_control;
  logic        tx_busy;
  logic        tx_write;
  logic        send_cmd;
  logic        rx_ack;
  logic        clear_errors;
  logic        tx_drop_event;
  logic        rx_capture;
  logic        rx_overrun_event;

  logic        rx_full_reg, rx_full_next;
  logic        rx_overrun_reg, rx_overrun_next;
  logic        tx_drop_reg, tx_drop_next;
  logic [31:0] rd_data;
  logic [31:0] q_mb_reg;

  logic [31:0] tx_word_reg [TX_WORDS];
  logic [31:0] rx_word_reg [TX_WORDS];

  // Window check by subtraction so a base near the top of the map cannot wrap.
  assign offset_full = address_dmem - ADDR_BASE;
  assign offset      = offset_full[3:0];
  assign mb_sel      = (address_dmem >= ADDR_BASE) && (offset_full[11:4] == 8'd0);

  assign wr_en        = wren & mb_sel;
  assign is_tx_word   = (offset[3:2] == 2'b00);
  assign is_control   = (offset == 4'd9);
  assign tx_busy      = (state_reg != TX_IDLE);
  assign tx_write     = wr_en & is_tx_word;
  assign send_cmd     = wr_en & is_control & data[0];
  assign rx_ack       = wr_en & is_control & data[1];
  assign clear_errors = wr_en & is_control & data[2];

  assign tx_drop_event    = tx_busy & (tx_write | send_cmd);
  // An ack in the same cycle frees the buffer before the strobe is considered.
  assign rx_capture       = rx_strobe & (~rx_full_reg | rx_ack);
  assign rx_overrun_event = rx_strobe & rx_full_reg & ~rx_ack;

  genvar gi;
  generate
    for (gi = 0; gi < TX_WORDS; gi++) begin : g_words
      always_ff @(posedge clock) begin
        if (reset) begin
          tx_word_reg[gi] <= 32'd0;
        end else if (tx_write && !tx_busy && (offset[1:0] == 2'(gi))) begin
          tx_word_reg[gi] <= data;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          rx_word_reg[gi] <= 32'd0;
        end else if (rx_capture) begin
          rx_word_reg[gi] <= message_in[32*gi +: 32];
        end
      end

      assign message_out[32*gi +: 32] = tx_word_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= TX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // DRAIN waits for done to fall so a lingering done cannot finish the next send.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TX_IDLE:  if (send_cmd) state_next = TX_SEND;
      TX_SEND:  if (done)     state_next = TX_DRAIN;
      TX_DRAIN: if (!done)    state_next = TX_IDLE;
      default:                state_next = TX_IDLE;
    endcase
  end

  assign data_ready = (state_reg == TX_SEND);

  always_comb begin
    rx_full_next    = rx_full_reg;
    rx_overrun_next = rx_overrun_reg;
    tx_drop_next    = tx_drop_reg;
    if (rx_capture) begin
      rx_full_next = 1'b1;
    end else if (rx_ack) begin
      rx_full_next = 1'b0;
    end
    // Error events in the same cycle as clear_errors keep the bit set.
    rx_overrun_next = (rx_overrun_reg & ~clear_errors) | rx_overrun_event;
    tx_drop_next    = (tx_drop_reg & ~clear_errors) | tx_drop_event;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_full_reg    <= 1'b0;
      rx_overrun_reg <= 1'b0;
      tx_drop_reg    <= 1'b0;
    end else begin
      rx_full_reg    <= rx_full_next;
      rx_overrun_reg <= rx_overrun_next;
      tx_drop_reg    <= tx_drop_next;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (offset)
      4'd0, 4'd1, 4'd2, 4'd3: rd_data = tx_word_reg[offset[1:0]];
      4'd4, 4'd5, 4'd6, 4'd7: rd_data = rx_word_reg[offset[1:0]];
      4'd8:    rd_data = {28'd0, tx_drop_reg, rx_overrun_reg, rx_full_reg, tx_busy};
      default: rd_data = 32'd0;
    endcase
  end

  // Registered read mirrors the syncram: returns contents as they were before this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_mb_reg <= 32'd0;
    end else begin
      q_mb_reg <= mb_sel ? rd_data : 32'd0;
    end
  end

  assign q_mb = q_mb_reg;

endmodule

// File: tb/tb_gpio_mailbox.sv
// Scoreboard bench for gpio_mailbox: driver updates a message-level model and queues expected reads;
// a negedge monitor pops and compares q_mb, plus data_ready, message_out and mb_sel every cycle.
module tb_gpio_mailbox;

  localparam logic [11:0] BASE = 12'hFF0;

  logic         clock = 1'b0;
  logic         reset;
  logic [11:0]  address_dmem;
  logic [31:0]  data;
  logic         wren;
  logic         mb_sel;
  logic [31:0]  q_mb;
  logic         data_ready;
  logic         done;
  logic [127:0] message_out;
  logic [127:0] message_in;
  logic         rx_strobe;

  always #5 clock = ~clock;

  gpio_mailbox #(.ADDR_BASE(BASE), .TX_WORDS(4)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
    .mb_sel(mb_sel), .q_mb(q_mb), .data_ready(data_ready), .done(done),
    .message_out(message_out), .message_in(message_in), .rx_strobe(rx_strobe)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    checks = 0;
  int    passed = 0;
  bit    rd_flag = 1'b0;
  string cur_name = "init";

  // Reference model: whole messages, a send phase (0 idle, 1 offering, 2 waiting done low), flags.
  logic [127:0] m_tx = '0;
  logic [127:0] m_rx = '0;
  int           m_phase = 0;
  bit           m_full = 1'b0;
  bit           m_ovr = 1'b0;
  bit           m_drop = 1'b0;

  function automatic bit in_window(logic [11:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 15);
  endfunction

  function automatic logic [31:0] model_read(logic [11:0] a);
    int off;
    if (!in_window(a)) return 32'd0;
    off = int'(a) - int'(BASE);
    if (off < 4) return m_tx[32*off +: 32];
    if (off < 8) return m_rx[32*(off-4) +: 32];
    if (off == 8) return {28'd0, m_drop, m_ovr, m_full, (m_phase != 0)};
    return 32'd0;
  endfunction

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  task automatic step();
    exp_t         e;
    logic [127:0] n_tx, n_rx;
    int           n_phase, off;
    bit           n_full, n_ovr, n_drop, wr, busy, send, ack, clr;
    e.name = cur_name;
    e.exp  = reset ? 32'd0 : model_read(address_dmem);
    off  = int'(address_dmem) - int'(BASE);
    wr   = wren && in_window(address_dmem);
    busy = (m_phase != 0);
    send = wr && off == 9 && data[0];
    ack  = wr && off == 9 && data[1];
    clr  = wr && off == 9 && data[2];
    n_tx = m_tx; n_rx = m_rx; n_phase = m_phase; n_full = m_full;
    n_ovr  = m_ovr && !clr;
    n_drop = m_drop && !clr;
    if (wr && off < 4) begin
      if (busy) n_drop = 1'b1;
      else n_tx[32*off +: 32] = data;
    end
    if (send && busy) n_drop = 1'b1;
    if (m_phase == 0 && send) n_phase = 1;
    else if (m_phase == 1 && done) n_phase = 2;
    else if (m_phase == 2 && !done) n_phase = 0;
    if (ack) n_full = 1'b0;
    if (rx_strobe) begin
      if (!n_full) begin
        n_rx = message_in;
        n_full = 1'b1;
      end else begin
        n_ovr = 1'b1;
      end
    end
    if (reset) begin
      n_tx = '0; n_rx = '0; n_phase = 0; n_full = 0; n_ovr = 0; n_drop = 0;
    end
    @(posedge clock);
    m_tx = n_tx; m_rx = n_rx; m_phase = n_phase; m_full = n_full; m_ovr = n_ovr; m_drop = n_drop;
    sb.push_back(e);
    rd_flag = 1'b1;
    #1;
  endtask

  task automatic cyc_addr(input logic [11:0] a, input logic [31:0] d, input bit we);
    address_dmem = a;
    data = d;
    wren = we;
    step();
    rx_strobe = 1'b0;
    wren = 1'b0;
  endtask

  task automatic cyc(input int off, input logic [31:0] d, input bit we);
    cyc_addr(BASE + 12'(off), d, we);
  endtask

  always @(negedge clock) begin
    if (rd_flag) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_empty: got no entry expected one");
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_q_mb"}, 128'(q_mb), 128'(mon_e.exp));
      end
      check({cur_name, "_data_ready"}, 128'(data_ready), 128'(m_phase == 1));
      check({cur_name, "_message_out"}, message_out, m_tx);
      check({cur_name, "_mb_sel"}, 128'(mb_sel), 128'(in_window(address_dmem)));
    end
  end

  initial begin
    reset = 1'b1; address_dmem = '0; data = '0; wren = 1'b0;
    done = 1'b0; message_in = '0; rx_strobe = 1'b0;
    cur_name = "reset";
    step(); step();
    reset = 1'b0;
    cur_name = "reset_status";
    cyc(8, 0, 0); cyc(8, 0, 0);

    cur_name = "tx_load";
    cyc(0, 32'h11111111, 1); cyc(1, 32'h22222222, 1);
    cyc(2, 32'h33333333, 1); cyc(3, 32'h44444444, 1);
    cyc(9, 32'h1, 1);
    cur_name = "tx_send";
    cyc(8, 0, 0); cyc(8, 0, 0);
    done = 1'b1; cur_name = "tx_done";
    repeat (3) cyc(8, 0, 0);
    done = 1'b0; cur_name = "tx_drain";
    cyc(8, 0, 0); cyc(8, 0, 0);
    for (int i = 0; i < 4; i++) cyc(i, 0, 0);

    cur_name = "tx_drop";
    cyc(9, 32'h1, 1);
    cyc(0, 32'hDEADBEEF, 1); cyc(9, 32'h1, 1);
    cyc(8, 0, 0); cyc(0, 0, 0);
    done = 1'b1; cyc(8, 0, 0);
    done = 1'b0; cyc(8, 0, 0);
    cur_name = "clear_drop";
    cyc(9, 32'h4, 1); cyc(8, 0, 0); cyc(8, 0, 0);

    cur_name = "rx_capture";
    message_in = 128'hAAAAAAAA_33333333_22222222_00000001; rx_strobe = 1'b1;
    cyc(8, 0, 0); cyc(4, 0, 0); cyc(7, 0, 0); cyc(8, 0, 0); cyc(8, 0, 0);
    cur_name = "rx_overrun";
    message_in = 128'h12345678_9ABCDEF0_0F0F0F0F_77777777; rx_strobe = 1'b1;
    cyc(8, 0, 0); cyc(4, 0, 0); cyc(8, 0, 0); cyc(8, 0, 0);
    cur_name = "rx_ack_strobe";
    cyc(9, 32'h4, 1);
    message_in = 128'h5; rx_strobe = 1'b1;
    cyc(9, 32'h2, 1); cyc(4, 0, 0); cyc(8, 0, 0); cyc(8, 0, 0);

    cur_name = "reset_in_send";
    cyc(9, 32'h1, 1); cyc(8, 0, 0);
    reset = 1'b1; cyc(8, 0, 0);
    reset = 1'b0; cyc(8, 0, 0); cyc(8, 0, 0);
    cyc_addr(12'h000, 32'h0, 0); cyc_addr(12'h000, 32'hFFFFFFFF, 1);

    cur_name = "random";
    for (int i = 0; i < 1500; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : BASE + 12'($urandom_range(0, 15));
      d = $urandom;
      if (a == BASE + 12'd9) d = d & 32'h7;
      if ($urandom_range(0, 3) == 0) done = ~done;
      rx_strobe = ($urandom_range(0, 9) == 0);
      message_in = {$urandom, $urandom, $urandom, $urandom};
      reset = ($urandom_range(0, 199) == 0);
      cyc_addr(a, d, ($urandom_range(0, 9) < 3));
    end
    reset = 1'b0;
    cur_name = "final";
    cyc(8, 0, 0);
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
